// File: rtl/tlb_refill_walker_pkg.sv
// Shared walker constants: address geometry, PTE field layout and FSM state encodings.
package tlb_refill_walker_pkg;

  localparam int ARCH_BITS      = 32;
  localparam int PAGE_BITS      = 12;
  localparam int PTE_BYTES_LOG2 = 2;

  localparam int PTE_VALID_BIT  = 0;
  localparam int PTE_PPN_MSB    = 31;
  localparam int PTE_PPN_LSB    = 12;

  typedef enum logic [2:0] {
    WALK_IDLE    = 3'd0,
    WALK_MEM_REQ = 3'd1,
    WALK_FILL    = 3'd2,
    WALK_DONE    = 3'd3,
    WALK_FAULT   = 3'd4
  } walkState_t;

endpackage

// File: rtl/tlb_refill_walker.sv
// Single-level page-table walker: fetches one PTE on a TLB miss and either fills
// the TLB with the translation or reports a one-cycle page fault.
module tlb_refill_walker #(
  parameter int ARCH_BITS      = 32,
  parameter int PAGE_BITS      = 12,
  parameter int PTE_BYTES_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 missReq,
  input  logic [ARCH_BITS-1:0] missVAddr,
  input  logic [ARCH_BITS-1:0] ptBase,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [ARCH_BITS-1:0] faultVAddr,
  output logic                 memReadReq,
  output logic [ARCH_BITS-1:0] memAddr,
  input  logic                 memAck,
  input  logic [ARCH_BITS-1:0] memData,
  output logic                 tlbWriteReq,
  output logic [ARCH_BITS-1:0] tlbVAddr,
  output logic [ARCH_BITS-1:0] tlbWriteAddr,
  input  logic                 tlbAck
);
  import tlb_refill_walker_pkg::*;

  localparam logic [ARCH_BITS-1:0] PPN_MASK =
    {{(ARCH_BITS-PAGE_BITS){1'b1}}, {PAGE_BITS{1'b0}}};

  walkState_t           state;
  logic [ARCH_BITS-1:0] vaddrReg;
  logic [ARCH_BITS-1:0] pteAddrReg;
  logic [ARCH_BITS-1:0] pteReg;

  // PTE address = base + VPN * PTE size; carry out of the top bit is dropped.
  function automatic logic [ARCH_BITS-1:0] pteAddrOf(input logic [ARCH_BITS-1:0] base,
                                                     input logic [ARCH_BITS-1:0] va);
    return base + ((va >> PAGE_BITS) << PTE_BYTES_LOG2);
  endfunction

  // The PTE address only changes when a walk is accepted, so it doubles as the held memAddr.
  assign memAddr = pteAddrReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WALK_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      memReadReq   <= 1'b0;
      tlbWriteReq  <= 1'b0;
      vaddrReg     <= '0;
      pteAddrReg   <= '0;
      pteReg       <= '0;
      faultVAddr   <= '0;
      tlbVAddr     <= '0;
      tlbWriteAddr <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        WALK_IDLE: begin
          if (missReq) begin
            vaddrReg   <= missVAddr;
            pteAddrReg <= pteAddrOf(ptBase, missVAddr);
            state      <= WALK_MEM_REQ;
            busy       <= 1'b1;
            memReadReq <= 1'b1;
          end
        end
        WALK_MEM_REQ: begin
          if (memAck) begin
            pteReg     <= memData;
            memReadReq <= 1'b0;
            if (memData[PTE_VALID_BIT]) begin
              state        <= WALK_FILL;
              tlbWriteReq  <= 1'b1;
              tlbVAddr     <= vaddrReg;
              tlbWriteAddr <= memData & PPN_MASK;
            end else begin
              state      <= WALK_FAULT;
              fault      <= 1'b1;
              faultVAddr <= vaddrReg;
            end
          end
        end
        WALK_FILL: begin
          // Keep the fill address tied to the latched PTE, not to the memory bus.
          tlbWriteAddr <= pteReg & PPN_MASK;
          if (tlbAck) begin
            tlbWriteReq <= 1'b0;
            state       <= WALK_DONE;
            done        <= 1'b1;
          end
        end
        WALK_DONE, WALK_FAULT: begin
          state <= WALK_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= WALK_IDLE;
          busy        <= 1'b0;
          memReadReq  <= 1'b0;
          tlbWriteReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: a timestamp-style walk model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        missReq;
  logic [31:0] missVAddr;
  logic [31:0] ptBase;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] faultVAddr;
  logic        memReadReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        tlbWriteReq;
  logic [31:0] tlbVAddr;
  logic [31:0] tlbWriteAddr;
  logic        tlbAck;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit started = 1'b0;

  tlb_refill_walker dut (
    .clk(clk), .rst(rst), .missReq(missReq), .missVAddr(missVAddr), .ptBase(ptBase),
    .busy(busy), .done(done), .fault(fault), .faultVAddr(faultVAddr),
    .memReadReq(memReadReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .tlbWriteReq(tlbWriteReq), .tlbVAddr(tlbVAddr), .tlbWriteAddr(tlbWriteAddr),
    .tlbAck(tlbAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a walk is a record of what has happened to it so far.
  bit          wActive, wMemSeen, wValid, wTlbSeen;
  logic [31:0] wVa, eMemAddr, eTlbVa, eTlbPa, eFaultVa;

  function automatic logic [31:0] expPteAddr(input logic [31:0] base, input logic [31:0] va);
    logic [63:0] s;
    s = 64'(base) + 64'(va / 32'd4096) * 64'd4;
    return s[31:0];
  endfunction

  initial begin
    wActive = 0; wMemSeen = 0; wValid = 0; wTlbSeen = 0;
    wVa = 0; eMemAddr = 0; eTlbVa = 0; eTlbPa = 0; eFaultVa = 0;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1'b1;
      if (rst) begin
        wActive = 0; wMemSeen = 0; wValid = 0; wTlbSeen = 0;
        wVa = 0; eMemAddr = 0; eTlbVa = 0; eTlbPa = 0; eFaultVa = 0;
      end else if (wActive && ((wMemSeen && !wValid) || wTlbSeen)) begin
        wActive = 0;
      end else if (!wActive) begin
        if (missReq) begin
          wActive = 1; wMemSeen = 0; wTlbSeen = 0; wValid = 0;
          wVa = missVAddr;
          eMemAddr = expPteAddr(ptBase, missVAddr);
        end
      end else if (!wMemSeen) begin
        if (memAck) begin
          wMemSeen = 1;
          wValid = memData[0];
          if (wValid) begin
            eTlbVa = wVa;
            eTlbPa = (memData / 32'd4096) * 32'd4096;
          end else begin
            eFaultVa = wVa;
          end
        end
      end else if (wValid && tlbAck) begin
        wTlbSeen = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("busy",         busy,         wActive);
        check("memReadReq",   memReadReq,   wActive && !wMemSeen);
        check("tlbWriteReq",  tlbWriteReq,  wActive && wMemSeen && wValid && !wTlbSeen);
        check("done",         done,         wActive && wTlbSeen);
        check("fault",        fault,        wActive && wMemSeen && !wValid);
        check("memAddr",      memAddr,      eMemAddr);
        check("tlbVAddr",     tlbVAddr,     eTlbVa);
        check("tlbWriteAddr", tlbWriteAddr, eTlbPa);
        check("faultVAddr",   faultVAddr,   eFaultVa);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  task automatic issue(input logic [31:0] base, input logic [31:0] va);
    @(negedge clk);
    ptBase = base; missVAddr = va; missReq = 1'b1; t0 = cyc;
    @(negedge clk);
    missReq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; missReq = 0; missVAddr = 0; ptBase = 0;
    memAck = 0; memData = 0; tlbAck = 0;
    idle(3);
    check("rst busy", busy, 0);
    check("rst memAddr", memAddr, 32'h0);
    check("rst faultVAddr", faultVAddr, 32'h0);
    check("rst tlbWriteAddr", tlbWriteAddr, 32'h0);
    rst = 1'b0;
    idle(2);

    // Valid walk, best-case timing
    issue(32'h0001_0000, 32'h0040_3ABC);
    check("walk memReadReq", memReadReq, 1);
    check("walk memAddr", memAddr, 32'h0001_100C);
    memAck = 1; memData = 32'h0008_7001;
    @(negedge clk);
    memAck = 0;
    check("walk tlbWriteReq", tlbWriteReq, 1);
    check("walk tlbVAddr", tlbVAddr, 32'h0040_3ABC);
    check("walk tlbWriteAddr", tlbWriteAddr, 32'h0008_7000);
    @(negedge clk);
    tlbAck = 1;
    @(negedge clk);
    tlbAck = 0;
    check("walk done", done, 1);
    check("walk latency", cyc - t0, 4);
    @(negedge clk);
    check("walk done width", done, 0);
    check("walk busy after", busy, 0);
    idle(2);

    // Invalid PTE
    issue(32'h0001_0000, 32'h0040_3ABC);
    memAck = 1; memData = 32'h0008_7000;
    @(negedge clk);
    memAck = 0;
    check("inv fault", fault, 1);
    check("inv faultVAddr", faultVAddr, 32'h0040_3ABC);
    check("inv tlbWriteReq", tlbWriteReq, 0);
    @(negedge clk);
    check("inv fault width", fault, 0);
    check("inv done", done, 0);
    idle(2);

    // Memory stall of 5 cycles, ptBase disturbed mid-walk; tlbAck already high on first FILL cycle
    issue(32'h0002_0000, 32'h0000_7123);
    ptBase = 32'hDEAD_0000;
    for (int i = 0; i < 6; i++) begin
      check("stall memReadReq", memReadReq, 1);
      check("stall memAddr", memAddr, 32'h0002_001C);
      if (i == 5) begin
        memAck = 1; memData = 32'h000A_B001;
      end
      @(negedge clk);
    end
    memAck = 0;
    tlbAck = 1;
    check("stall tlbWriteAddr", tlbWriteAddr, 32'h000A_B000);
    @(negedge clk);
    tlbAck = 0;
    check("stall done", done, 1);
    idle(2);

    // Second miss while busy is dropped
    issue(32'h0001_0000, 32'h0050_0000);
    missReq = 1; missVAddr = 32'h1234_5000;
    idle(2);
    missReq = 0;
    check("busy memAddr", memAddr, 32'h0001_1400);
    memAck = 1; memData = 32'h0012_3001;
    @(negedge clk);
    memAck = 0;
    check("busy tlbVAddr", tlbVAddr, 32'h0050_0000);
    @(negedge clk);
    tlbAck = 1;
    @(negedge clk);
    tlbAck = 0;
    check("busy done", done, 1);
    @(negedge clk);
    check("busy cleared", busy, 0);
    idle(3);

    // Reset while filling
    issue(32'h0001_0000, 32'h0040_3ABC);
    memAck = 1; memData = 32'h0008_7001;
    @(negedge clk);
    memAck = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstFill tlbWriteReq", tlbWriteReq, 0);
    check("rstFill busy", busy, 0);
    idle(3);
    check("rstFill no done", done, 0);

    // Reset while a memAck is pending
    issue(32'h0001_0000, 32'h0040_3ABC);
    rst = 1; memAck = 1; memData = 32'h0008_7001;
    @(negedge clk);
    rst = 0; memAck = 0;
    check("rstMem busy", busy, 0);
    check("rstMem memAddr", memAddr, 32'h0);
    @(negedge clk);
    check("rstMem tlbWriteReq", tlbWriteReq, 0);
    idle(2);

    // Address wraparound
    issue(32'hFFFF_F000, 32'h0000_5000);
    check("wrap1 memAddr", memAddr, 32'hFFFF_F014);
    memAck = 1; memData = 32'h0000_0000;
    @(negedge clk);
    memAck = 0;
    check("wrap1 fault", fault, 1);
    idle(2);
    issue(32'hFFFF_FFFC, 32'h0000_1000);
    check("wrap2 memAddr", memAddr, 32'h0000_0000);
    memAck = 1; memData = 32'h0000_1001;
    @(negedge clk);
    memAck = 0;
    tlbAck = 1;
    @(negedge clk);
    tlbAck = 0;
    check("wrap2 done", done, 1);
    check("wrap2 faultVAddr held", faultVAddr, 32'h0000_5000);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
